// File: rtl/demux_y_out_32ch.sv
// demux_y_out_32ch
// Return path of the interleaved channel datapath. On a sample strobe it walks
// the shared input mux through every channel, one index per clock. Each issued
// index is carried down a PIPE_LAT-deep token line that matches the datapath
// latency. When a token comes out, the result on y_in belongs to that channel
// and goes into a shadow bank. The exit of the last channel's token commits the
// whole bank to y_out_flat in one edge and pulses frame_valid.
//
// Ports:
//   clk           rising-edge clock
//   GlobalReset   synchronous active-high reset
//   sample_start  one-cycle strobe that starts a frame (ignored while busy)
//   x_adc_select  registered channel select to the input mux
//   y_in          interleaved datapath result
//   busy          frame in progress
//   frame_valid   one-cycle pulse when y_out_flat has just been updated
//   overrun       one-cycle pulse when a sample_start was dropped while busy
//   y_out_flat    channel k at [k*DW +: DW], held between commits
module demux_y_out_32ch #(
    parameter int NUM_CH   = 32,
    parameter int SEL_W    = 5,
    parameter int DW       = 21,
    parameter int PIPE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 sample_start,
    output logic [SEL_W-1:0]     x_adc_select,
    input  logic [DW-1:0]        y_in,
    output logic                 busy,
    output logic                 frame_valid,
    output logic                 overrun,
    output logic [NUM_CH*DW-1:0] y_out_flat
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state;

    // Token line: stage 0 holds the index issued at the most recent edge.
    // The last stage holds the index whose result is on y_in now.
    logic             tok_vld_p [PIPE_LAT];
    logic [SEL_W-1:0] tok_idx_p [PIPE_LAT];

    logic                 tok_in_vld;
    logic [SEL_W-1:0]     tok_in_idx;
    logic                 exit_vld;
    logic [SEL_W-1:0]     exit_idx;
    logic                 commit;
    logic [NUM_CH*DW-1:0] shadow;
    logic [NUM_CH*DW-1:0] shadow_next;

    always_comb begin
        tok_in_vld  = (state == ISSUE) || ((state == IDLE) && sample_start);
        tok_in_idx  = (state == ISSUE) ? (x_adc_select + SEL_W'(1)) : '0;
        exit_vld    = tok_vld_p[PIPE_LAT-1];
        exit_idx    = tok_idx_p[PIPE_LAT-1];
        commit      = exit_vld && (exit_idx == SEL_W'(NUM_CH - 1));
        // The commit must include the capture that happens on the same edge,
        // so the output bus loads from the merged view, not from the old bank.
        shadow_next = shadow;
        if (exit_vld) begin
            shadow_next[exit_idx*DW +: DW] = y_in;
        end
    end

    // ---- stage p0..p(PIPE_LAT-1): index token delay line ----
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tok_vld_p[i] <= 1'b0;
            end
        end else begin
            tok_vld_p[0] <= tok_in_vld;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tok_vld_p[i] <= tok_vld_p[i-1];
            end
        end
        tok_idx_p[0] <= tok_in_idx;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tok_idx_p[i] <= tok_idx_p[i-1];
        end
    end

    // ---- capture stage: shadow bank ----
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_next;
        end
    end

    // ---- control FSM and registered outputs ----
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state        <= IDLE;
            x_adc_select <= '0;
            busy         <= 1'b0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
            y_out_flat   <= '0;
        end else begin
            frame_valid <= 1'b0;
            overrun     <= sample_start && busy;
            case (state)
                IDLE: begin
                    if (sample_start) begin
                        state        <= ISSUE;
                        x_adc_select <= '0;
                        busy         <= 1'b1;
                    end
                end
                ISSUE: begin
                    x_adc_select <= x_adc_select + SEL_W'(1);
                    // The select stops at NUM_CH-1, so unused codes never appear.
                    if (x_adc_select == SEL_W'(NUM_CH - 2)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (commit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_valid <= 1'b1;
                        y_out_flat  <= shadow_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_y_out_32ch.sv
module tb_demux_y_out_32ch;

    localparam int NUM_CH = 32;
    localparam int SEL_W  = 5;
    localparam int DW     = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 ss1, ss3;
    logic [SEL_W-1:0]     sel1, sel3;
    logic [DW-1:0]        y1, y3, base1, base3, a3, b3;
    logic                 busy1, fv1, ovr1, busy3, fv3, ovr3;
    logic [NUM_CH*DW-1:0] flat1, flat3;

    int errors = 0;
    int checks = 0;

    // Datapath models: a bare mux for PIPE_LAT=1, and a mux plus two registers for PIPE_LAT=3.
    assign y1 = base1 + DW'(sel1);
    always @(posedge clk) begin
        a3 <= base3 + DW'(sel3);
        b3 <= a3;
    end
    assign y3 = b3;

    demux_y_out_32ch #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DW(DW), .PIPE_LAT(1)) dut (
        .clk(clk), .GlobalReset(rst), .sample_start(ss1), .x_adc_select(sel1),
        .y_in(y1), .busy(busy1), .frame_valid(fv1), .overrun(ovr1), .y_out_flat(flat1)
    );

    demux_y_out_32ch #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DW(DW), .PIPE_LAT(3)) dut3 (
        .clk(clk), .GlobalReset(rst), .sample_start(ss3), .x_adc_select(sel3),
        .y_in(y3), .busy(busy3), .frame_valid(fv3), .overrun(ovr3), .y_out_flat(flat3)
    );

    task automatic test_reset();
        rst = 1'b1; ss1 = 1'b0; ss3 = 1'b0; base1 = '0; base3 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (sel1 !== '0 || busy1 !== 1'b0 || fv1 !== 1'b0 || ovr1 !== 1'b0 || flat1 !== '0) begin
                errors++;
                $display("FAIL reset_idle_pl1 cycle %0d: sel=%0d busy=%b fv=%b ovr=%b flat_zero=%b, expected all zero",
                         c, sel1, busy1, fv1, ovr1, (flat1 === '0));
            end
            checks++;
            if (sel3 !== '0 || busy3 !== 1'b0 || fv3 !== 1'b0 || ovr3 !== 1'b0 || flat3 !== '0) begin
                errors++;
                $display("FAIL reset_idle_pl3 cycle %0d: sel=%0d busy=%b fv=%b ovr=%b flat_zero=%b, expected all zero",
                         c, sel3, busy3, fv3, ovr3, (flat3 === '0));
            end
        end
    endtask

    // Ends positioned in the frame_valid cycle.
    task automatic test_default();
        base1 = 21'h100000;
        ss1 = 1'b1;
        @(negedge clk);
        ss1 = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            checks++;
            if (sel1 !== SEL_W'((k > 31) ? 31 : k)) begin
                errors++;
                $display("FAIL default_sel edge %0d: got %0d, expected %0d", k, sel1, (k > 31) ? 31 : k);
            end
            checks++;
            if (fv1 !== (k == 32)) begin
                errors++;
                $display("FAIL default_fv edge %0d: got %b, expected %b", k, fv1, (k == 32));
            end
            checks++;
            if (busy1 !== (k < 32)) begin
                errors++;
                $display("FAIL default_busy edge %0d: got %b, expected %b", k, busy1, (k < 32));
            end
            checks++;
            if (ovr1 !== 1'b0) begin
                errors++;
                $display("FAIL default_ovr edge %0d: got %b, expected 0", k, ovr1);
            end
            if (k < 32) begin
                checks++;
                if (flat1 !== '0) begin
                    errors++;
                    $display("FAIL default_partial edge %0d: y_out_flat changed before commit", k);
                end
                @(negedge clk);
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (flat1[ch*DW +: DW] !== 21'h100000 + DW'(ch)) begin
                errors++;
                $display("FAIL default_data ch %0d: got %h, expected %h", ch, flat1[ch*DW +: DW], 21'h100000 + DW'(ch));
            end
        end
    endtask

    // Starts in the frame_valid cycle left by test_default.
    task automatic test_back_to_back();
        base1 = 21'h000040;
        ss1 = 1'b1;
        @(negedge clk);
        ss1 = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            checks++;
            if (sel1 !== SEL_W'((k > 31) ? 31 : k)) begin
                errors++;
                $display("FAIL b2b_sel edge %0d: got %0d, expected %0d", k, sel1, (k > 31) ? 31 : k);
            end
            checks++;
            if (fv1 !== (k == 32) || ovr1 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_fv_ovr edge %0d: fv=%b ovr=%b, expected fv=%b ovr=0", k, fv1, ovr1, (k == 32));
            end
            if (k == 16) begin
                checks++;
                if (flat1[5*DW +: DW] !== 21'h100005) begin
                    errors++;
                    $display("FAIL b2b_hold ch 5: got %h, expected 100005", flat1[5*DW +: DW]);
                end
            end
            if (k < 32) @(negedge clk);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (flat1[ch*DW +: DW] !== 21'h000040 + DW'(ch)) begin
                errors++;
                $display("FAIL b2b_data ch %0d: got %h, expected %h", ch, flat1[ch*DW +: DW], 21'h000040 + DW'(ch));
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pipe_lat3();
        base3 = 21'h015000;
        repeat (2) @(negedge clk);
        ss3 = 1'b1;
        @(negedge clk);
        ss3 = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            checks++;
            if (sel3 !== SEL_W'((k > 31) ? 31 : k)) begin
                errors++;
                $display("FAIL pl3_sel edge %0d: got %0d, expected %0d", k, sel3, (k > 31) ? 31 : k);
            end
            checks++;
            if (fv3 !== (k == 34) || busy3 !== (k < 34)) begin
                errors++;
                $display("FAIL pl3_fv_busy edge %0d: fv=%b busy=%b, expected fv=%b busy=%b",
                         k, fv3, busy3, (k == 34), (k < 34));
            end
            if (k < 34) begin
                checks++;
                if (flat3 !== '0) begin
                    errors++;
                    $display("FAIL pl3_partial edge %0d: y_out_flat changed before commit", k);
                end
                @(negedge clk);
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (flat3[ch*DW +: DW] !== 21'h015000 + DW'(ch)) begin
                errors++;
                $display("FAIL pl3_data ch %0d: got %h, expected %h", ch, flat3[ch*DW +: DW], 21'h015000 + DW'(ch));
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun();
        base1 = 21'h001500;
        ss1 = 1'b1;
        @(negedge clk);
        ss1 = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            checks++;
            if (ovr1 !== (k == 10)) begin
                errors++;
                $display("FAIL ovr_pulse edge %0d: got %b, expected %b", k, ovr1, (k == 10));
            end
            checks++;
            if (fv1 !== (k == 32)) begin
                errors++;
                $display("FAIL ovr_fv edge %0d: got %b, expected %b", k, fv1, (k == 32));
            end
            if (k <= 31) begin
                checks++;
                if (sel1 !== SEL_W'(k)) begin
                    errors++;
                    $display("FAIL ovr_sel edge %0d: got %0d, expected %0d", k, sel1, k);
                end
            end
            ss1 = (k == 9);
            @(negedge clk);
        end
        ss1 = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (flat1[ch*DW +: DW] !== 21'h001500 + DW'(ch)) begin
                errors++;
                $display("FAIL ovr_data ch %0d: got %h, expected %h", ch, flat1[ch*DW +: DW], 21'h001500 + DW'(ch));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        base1 = 21'h003000;
        ss1 = 1'b1;
        @(negedge clk);
        ss1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rst = (k == 19);
            @(negedge clk);
        end
        rst = 1'b0;
        checks++;
        if (sel1 !== '0 || busy1 !== 1'b0 || fv1 !== 1'b0 || ovr1 !== 1'b0 || flat1 !== '0) begin
            errors++;
            $display("FAIL midreset_clear: sel=%0d busy=%b fv=%b ovr=%b flat_zero=%b, expected all zero",
                     sel1, busy1, fv1, ovr1, (flat1 === '0));
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (fv1 !== 1'b0 || busy1 !== 1'b0 || flat1 !== '0) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: fv=%b busy=%b flat_zero=%b, expected 0 0 1",
                         c, fv1, busy1, (flat1 === '0));
            end
        end
        base1 = 21'h005000;
        ss1 = 1'b1;
        @(negedge clk);
        ss1 = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            checks++;
            if (fv1 !== (k == 32)) begin
                errors++;
                $display("FAIL midreset_fresh_fv edge %0d: got %b, expected %b", k, fv1, (k == 32));
            end
            if (k < 32) @(negedge clk);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (flat1[ch*DW +: DW] !== 21'h005000 + DW'(ch)) begin
                errors++;
                $display("FAIL midreset_fresh_data ch %0d: got %h, expected %h", ch, flat1[ch*DW +: DW], 21'h005000 + DW'(ch));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_pipe_lat3();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
